nonrev_divider: RTL and testbench
=================================

Name: nonrev_divider

Overview:
- Sequential restoring unsigned divider; the inverse of the shift-add multiplier in the non-reversible ALU datapath.
- Computes quotient and remainder of dividend / divisor, one quotient bit per clock.
- Uses a start/busy/done handshake.
- Intended as the divide operation alongside add/sub/mul/shift in the ALU, and as the golden reference for a later reversible divider.

Parameters:
- WIDTH, 16, operand/quotient/remainder width in bits (minimum 2).

Ports:
- clk  input  1  system clock, rising-edge.
- rst  input  1  asynchronous, active-high reset.
- start  input  1  request; sampled only when busy=0.
- dividend  input  WIDTH  numerator, unsigned.
- divisor  input  WIDTH  denominator, unsigned.
- quotient  output  WIDTH  registered result.
- remainder  output  WIDTH  registered result.
- busy  output  1  high while an operation is in progress.
- done  output  1  one-cycle pulse when results become valid.
- div_by_zero  output  1  registered flag; valid with done, held with results.

Behaviour:
- Clock/reset: one clock (clk); reset is asynchronous and active-high (rst).
- Reset: asserting rst at any time, including mid-operation, immediately forces:
  - state=IDLE, busy=0, done=0, div_by_zero=0
  - quotient=0, remainder=0
  - internal count/shift registers=0
  - the aborted operation produces no done.
- States: IDLE, RUN.
- IDLE:
  - start=1 at edge k latches dividend into Q shift register, divisor into D, clears partial remainder R (WIDTH+1 bits), count=0.
  - At that edge: state→RUN, busy=1.
  - div_by_zero is registered from (divisor==0) at edge k.
- RUN, each edge, one restoring step:
  - R'={R[WIDTH-1:0],Q[WIDTH-1]}; T=R'−{1'b0,D}.
  - No borrow: R=T, Q={Q[WIDTH-2:0],1}.
  - Borrow: R=R', Q={Q[WIDTH-2:0],0}.
  - count increments.
- Completion:
  - On the edge performing step WIDTH (edge k+WIDTH), quotient/remainder load the final Q/R[WIDTH-1:0].
  - At the same edge: done=1 for exactly one cycle, busy=0, state→IDLE.
  - Latency from start edge to done visible: WIDTH cycles.
- Output hold: quotient, remainder and div_by_zero change only at completion (or reset) and hold until the next completion.
- start while busy=1: ignored, no queuing. Operands are sampled only at accept; input changes during RUN have no effect.
- Back-to-back: start=1 in the done cycle (busy=0) is accepted at the next edge.
- Divide by zero:
  - The algorithm runs unmodified and yields quotient={WIDTH{1}}, remainder=dividend.
  - div_by_zero=1. Latency unchanged (unless the optional feature is enabled).
- Arithmetic:
  - All unsigned; R carries one extra bit for the borrow.
  - Invariant: dividend = quotient*divisor + remainder, remainder < divisor, whenever divisor≠0.

Optional Feature:
- Macro: DIV_ZERO_FAST_EN.
- Defined:
  - When start is accepted with divisor==0, state stays IDLE and busy never asserts.
  - At the next edge (k+1): quotient={WIDTH{1}}, remainder=dividend, div_by_zero=1, done pulses.
  - Latency is 1 cycle; start in that done cycle is accepted normally.
- Undefined: divide by zero takes the full WIDTH-cycle path as described above.

Decomposition:
- Shared package nonrev_alu_pkg holds:
  - ALU_WIDTH=16
  - state encoding constants DIV_IDLE=1'b0, DIV_RUN=1'b1
  - count width constant DIV_CNT_W=$clog2(ALU_WIDTH+1).
- One natural sub-module: div_step.
  - Combinational single restoring iteration.
  - Inputs: R, Q msb, D. Outputs: next R, quotient bit.
  - Unit-testable in isolation; the top holds the FSM, counter and registers.

Test Plan:
- Basic divide: dividend=100, divisor=7, start one cycle → busy=1 next cycle; done exactly 16 cycles after the accept edge; quotient=14, remainder=2, div_by_zero=0.
- Max operands: dividend=0xFFFF, divisor=1 → quotient=0xFFFF, remainder=0; then dividend=0x1234, divisor=0xFFFF → quotient=0, remainder=0x1234.
- Divide by zero: dividend=5, divisor=0 → quotient=0xFFFF, remainder=5, div_by_zero=1.
  - Macro undefined: done at cycle 16.
  - DIV_ZERO_FAST_EN defined: done at cycle 1, busy stays 0.
- Ignored start: start 200/9; at cycle 5 pulse start with 50/5 and change the inputs → result quotient=22, remainder=2; exactly one done pulse.
- Reset mid-operation: start 1000/3, assert rst at cycle 8 → outputs 0 immediately, no done; after release, 1000/3 → quotient=333, remainder=1.
- Back-to-back: assert start with 81/9 in the done cycle of 17/4 → first result 4/1, second done 16 cycles later with 9/0.

Source files
------------

// File: rtl/nonrev_alu_pkg.sv
// Shared definitions for the non-reversible ALU datapath.
//   ALU_WIDTH  : default datapath width
//   DIV_CNT_W  : divider step-counter width for ALU_WIDTH
//   div_state_e: divider FSM encoding (DIV_IDLE / DIV_RUN)
package nonrev_alu_pkg;

  localparam int unsigned ALU_WIDTH = 16;
  localparam int unsigned DIV_CNT_W = $clog2(ALU_WIDTH + 1);

  typedef enum logic {
    DIV_IDLE = 1'b0,
    DIV_RUN  = 1'b1
  } div_state_e;

endpackage

// File: rtl/div_step.sv
// One combinational restoring-division iteration.
// Ports:
//   r_i      : partial remainder (WIDTH+1 bits)
//   q_msb_i  : dividend/quotient shift-register msb shifted into R
//   d_i      : divisor
//   r_next_o : partial remainder after this step
//   q_bit_o  : quotient bit produced by this step (1 = subtraction kept)
import nonrev_alu_pkg::*;

module div_step #(
  parameter int unsigned WIDTH = ALU_WIDTH
) (
  input  logic [WIDTH:0]   r_i,
  input  logic             q_msb_i,
  input  logic [WIDTH-1:0] d_i,
  output logic [WIDTH:0]   r_next_o,
  output logic             q_bit_o
);

  logic [WIDTH:0] r_shift;

  always_comb begin
    r_shift  = {r_i[WIDTH-1:0], q_msb_i};
    // Compare against the full shifted value {R, q}; equivalent to testing the borrow of R'-D.
    q_bit_o  = ({r_i, q_msb_i} >= {2'b00, d_i});
    r_next_o = q_bit_o ? (r_shift - {1'b0, d_i}) : r_shift;
  end

endmodule

// File: rtl/nonrev_divider.sv
// Sequential restoring unsigned divider, one quotient bit per clock.
// Ports:
//   clk, rst    : clock, asynchronous active-high reset
//   start       : request, sampled only while busy=0
//   dividend    : numerator (unsigned)
//   divisor     : denominator (unsigned)
//   quotient    : registered result
//   remainder   : registered result
//   busy        : operation in progress
//   done        : one-cycle pulse when results update
//   div_by_zero : registered flag, updated with results
// Optional macro DIV_ZERO_FAST_EN: a zero divisor completes one cycle after
// accept without entering RUN.
import nonrev_alu_pkg::*;

module nonrev_divider #(
  parameter int unsigned WIDTH = ALU_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             busy,
  output logic             done,
  output logic             div_by_zero
);

  localparam int unsigned CNT_W = $clog2(WIDTH + 1);

  div_state_e       state_q, state_d;
  logic [WIDTH-1:0] q_q, q_d;
  logic [WIDTH:0]   r_q, r_d;
  logic [WIDTH-1:0] d_q, d_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             dz_q, dz_d;
  logic [WIDTH-1:0] quotient_q, quotient_d;
  logic [WIDTH-1:0] remainder_q, remainder_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             dbz_q, dbz_d;
`ifdef DIV_ZERO_FAST_EN
  logic             zpend_q, zpend_d;
`endif

  logic [WIDTH:0]   step_r;
  logic             step_bit;

  div_step #(.WIDTH(WIDTH)) u_step (
    .r_i      (r_q),
    .q_msb_i  (q_q[WIDTH-1]),
    .d_i      (d_q),
    .r_next_o (step_r),
    .q_bit_o  (step_bit)
  );

  // Next-state and datapath control.
  always_comb begin
    state_d     = state_q;
    q_d         = q_q;
    r_d         = r_q;
    d_d         = d_q;
    cnt_d       = cnt_q;
    dz_d        = dz_q;
    quotient_d  = quotient_q;
    remainder_d = remainder_q;
    busy_d      = busy_q;
    done_d      = 1'b0;
    dbz_d       = dbz_q;
`ifdef DIV_ZERO_FAST_EN
    zpend_d     = 1'b0;
`endif

    case (state_q)
      DIV_IDLE: begin
`ifdef DIV_ZERO_FAST_EN
        // Finish a zero-divisor request accepted last cycle; q_q still holds its dividend.
        if (zpend_q) begin
          quotient_d  = '1;
          remainder_d = q_q;
          dbz_d       = 1'b1;
          done_d      = 1'b1;
        end
`endif
        if (start) begin
          q_d   = dividend;
          d_d   = divisor;
          r_d   = '0;
          cnt_d = '0;
          dz_d  = (divisor == '0);
`ifdef DIV_ZERO_FAST_EN
          if (divisor == '0) begin
            zpend_d = 1'b1;
          end else begin
            state_d = DIV_RUN;
            busy_d  = 1'b1;
          end
`else
          state_d = DIV_RUN;
          busy_d  = 1'b1;
`endif
        end
      end

      DIV_RUN: begin
        r_d   = step_r;
        q_d   = {q_q[WIDTH-2:0], step_bit};
        cnt_d = cnt_q + CNT_W'(1);
        // Last step: publish results directly from the step outputs.
        if (cnt_q == CNT_W'(WIDTH - 1)) begin
          quotient_d  = {q_q[WIDTH-2:0], step_bit};
          remainder_d = step_r[WIDTH-1:0];
          dbz_d       = dz_q;
          done_d      = 1'b1;
          busy_d      = 1'b0;
          state_d     = DIV_IDLE;
        end
      end

      default: begin
        state_d = DIV_IDLE;
        busy_d  = 1'b0;
      end
    endcase
  end

  // State and result registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= DIV_IDLE;
      q_q         <= '0;
      r_q         <= '0;
      d_q         <= '0;
      cnt_q       <= '0;
      dz_q        <= 1'b0;
      quotient_q  <= '0;
      remainder_q <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      dbz_q       <= 1'b0;
`ifdef DIV_ZERO_FAST_EN
      zpend_q     <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      q_q         <= q_d;
      r_q         <= r_d;
      d_q         <= d_d;
      cnt_q       <= cnt_d;
      dz_q        <= dz_d;
      quotient_q  <= quotient_d;
      remainder_q <= remainder_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      dbz_q       <= dbz_d;
`ifdef DIV_ZERO_FAST_EN
      zpend_q     <= zpend_d;
`endif
    end
  end

  assign quotient    = quotient_q;
  assign remainder   = remainder_q;
  assign busy        = busy_q;
  assign done        = done_q;
  assign div_by_zero = dbz_q;

endmodule

// File: tb/tb_nonrev_divider.sv
// Self-checking bench for nonrev_divider: directed cases plus random operands
// compared against plain integer division.
module tb_nonrev_divider;

  localparam int unsigned W = 16;

  logic         clk = 1'b0;
  logic         rst;
  logic         start;
  logic [W-1:0] dividend;
  logic [W-1:0] divisor;
  logic [W-1:0] quotient;
  logic [W-1:0] remainder;
  logic         busy;
  logic         done;
  logic         div_by_zero;

  int total = 0;
  int bad   = 0;

  logic [W-1:0] prev_q;
  logic [W-1:0] prev_r;

  nonrev_divider #(.WIDTH(W)) dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .dividend    (dividend),
    .divisor     (divisor),
    .quotient    (quotient),
    .remainder   (remainder),
    .busy        (busy),
    .done        (done),
    .div_by_zero (div_by_zero)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic int exp_lat(input logic [W-1:0] b);
`ifdef DIV_ZERO_FAST_EN
    return (b == '0) ? 1 : int'(W);
`else
    return int'(W);
`endif
  endfunction

  function automatic logic exp_busy(input logic [W-1:0] b);
`ifdef DIV_ZERO_FAST_EN
    return (b != '0);
`else
    return 1'b1;
`endif
  endfunction

  // Drive a request for one cycle; returns right after the accept edge.
  task automatic launch(input string tag, input logic [W-1:0] a, input logic [W-1:0] b);
    dividend = a;
    divisor  = b;
    start    = 1'b1;
    tick();
    start    = 1'b0;
    chk({tag, "_busy_on_accept"}, 32'(busy), 32'(exp_busy(b)));
    chk({tag, "_no_early_done"}, 32'(done), 32'd0);
  endtask

  // Wait for done, checking that results hold meanwhile; lat=-1 on timeout.
  task automatic wait_done(input string tag, input int maxc, output int lat);
    lat = -1;
    for (int i = 1; i <= maxc; i++) begin
      tick();
      if (done === 1'b1) begin
        lat = i;
        break;
      end
      chk({tag, "_hold_q"}, 32'(quotient), 32'(prev_q));
      chk({tag, "_hold_r"}, 32'(remainder), 32'(prev_r));
    end
  endtask

  task automatic check_result(input string tag, input logic [W-1:0] a, input logic [W-1:0] b,
                              input int lat, input int elat);
    logic [W-1:0] eq, er;
    logic         ez;
    if (b == '0) begin
      eq = '1;
      er = a;
      ez = 1'b1;
    end else begin
      eq = a / b;
      er = a % b;
      ez = 1'b0;
    end
    chk({tag, "_latency"}, 32'(lat), 32'(elat));
    chk({tag, "_quotient"}, 32'(quotient), 32'(eq));
    chk({tag, "_remainder"}, 32'(remainder), 32'(er));
    chk({tag, "_dbz"}, 32'(div_by_zero), 32'(ez));
    chk({tag, "_busy_low"}, 32'(busy), 32'd0);
    prev_q = eq;
    prev_r = er;
  endtask

  task automatic run_op(input string tag, input logic [W-1:0] a, input logic [W-1:0] b);
    int lat;
    launch(tag, a, b);
    wait_done(tag, 40, lat);
    check_result(tag, a, b, lat, exp_lat(b));
    tick();
    chk({tag, "_done_one_cycle"}, 32'(done), 32'd0);
  endtask

  initial begin
    int lat;
    int pulses;
    logic [W-1:0] a, b;

    rst      = 1'b1;
    start    = 1'b0;
    dividend = '0;
    divisor  = '0;
    prev_q   = '0;
    prev_r   = '0;
    #12;
    chk("reset_quotient", 32'(quotient), 32'd0);
    chk("reset_remainder", 32'(remainder), 32'd0);
    chk("reset_busy", 32'(busy), 32'd0);
    chk("reset_done", 32'(done), 32'd0);
    chk("reset_dbz", 32'(div_by_zero), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    tick();

    run_op("basic_100_7", 16'd100, 16'd7);
    run_op("max_ffff_1", 16'hFFFF, 16'd1);
    run_op("small_1234_ffff", 16'h1234, 16'hFFFF);
    run_op("dbz_5_0", 16'd5, 16'd0);
    run_op("after_dbz_9_3", 16'd9, 16'd3);

    // Start pulsed mid-run with new operands must be ignored.
    launch("ignored", 16'd200, 16'd9);
    repeat (4) tick();
    dividend = 16'd50;
    divisor  = 16'd5;
    start    = 1'b1;
    tick();
    start    = 1'b0;
    dividend = 16'hABCD;
    divisor  = 16'd3;
    wait_done("ignored", 40, lat);
    check_result("ignored", 16'd200, 16'd9, lat, int'(W) - 5);
    pulses = 0;
    for (int i = 0; i < 24; i++) begin
      tick();
      if (done === 1'b1) pulses++;
    end
    chk("ignored_single_done", 32'(pulses), 32'd0);
    chk("ignored_not_queued", 32'(busy), 32'd0);

    // Reset in the middle of an operation.
    launch("midrst", 16'd1000, 16'd3);
    repeat (7) tick();
    rst = 1'b1;
    #1;
    chk("midrst_quotient", 32'(quotient), 32'd0);
    chk("midrst_remainder", 32'(remainder), 32'd0);
    chk("midrst_busy", 32'(busy), 32'd0);
    chk("midrst_done", 32'(done), 32'd0);
    chk("midrst_dbz", 32'(div_by_zero), 32'd0);
    prev_q = '0;
    prev_r = '0;
    tick();
    @(negedge clk);
    rst = 1'b0;
    pulses = 0;
    for (int i = 0; i < 24; i++) begin
      tick();
      if (done === 1'b1) pulses++;
    end
    chk("midrst_no_done", 32'(pulses), 32'd0);
    run_op("after_rst_1000_3", 16'd1000, 16'd3);

    // Back-to-back: new start issued in the done cycle.
    launch("b2b_first", 16'd17, 16'd4);
    wait_done("b2b_first", 40, lat);
    check_result("b2b_first", 16'd17, 16'd4, lat, int'(W));
    launch("b2b_second", 16'd81, 16'd9);
    wait_done("b2b_second", 40, lat);
    check_result("b2b_second", 16'd81, 16'd9, lat, int'(W));
    tick();

    // Random operands, with divisor magnitudes spread across the range.
    for (int n = 0; n < 24; n++) begin
      a = W'($urandom);
      case ($urandom_range(0, 3))
        0:       b = W'($urandom_range(0, 15));
        1:       b = W'($urandom);
        2:       b = a >> $urandom_range(0, 15);
        default: b = W'($urandom_range(1, 255));
      endcase
      run_op($sformatf("rand%0d", n), a, b);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
